// File: rtl/regfile_2r1w_sb_pkg.sv
// rtl/regfile_2r1w_sb_pkg.sv - shared register-file defaults, architectural indices and address helper
package regfile_2r1w_sb_pkg;

  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_DEPTH = 8;

  localparam logic [31:0] REG_ZERO = 32'd0;

  // True when addr names a real entry that can hold data (and be marked busy).
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth,
                                   input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == REG_ZERO));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with range check, zero mask and write bypass
module regfile_rd_port
  import regfile_2r1w_sb_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         re,
  input  logic [AW-1:0]                raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic                         we_ok,
  input  logic [AW-1:0]                waddr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata
);

  logic             rd_ok;
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_comb begin
    rd_ok   = addr_ok(32'(raddr), DEPTH, ZERO_REG);
    rdata_d = rdata_q;
    if (rst) begin
      rdata_d = '0;
    end else if (re) begin
      if (!rd_ok) begin
        rdata_d = '0;
      end else if (BYPASS && we_ok && (waddr == raddr)) begin
        // we_ok already excludes dropped writes, so only real writes forward
        rdata_d = wdata;
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read/1-write register file with per-entry busy scoreboard
module regfile_2r1w_sb
  import regfile_2r1w_sb_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             bset,
  input  logic [AW-1:0]    baddr,
  output logic             busy_a,
  output logic             busy_b,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            busy_d;
  logic [DEPTH-1:0]            busy_q;
  logic                        we_ok;
  logic                        bset_ok;

  always_comb begin
    we_ok   = we && addr_ok(32'(waddr), DEPTH, ZERO_REG);
    bset_ok = bset && addr_ok(32'(baddr), DEPTH, ZERO_REG);
    mem_d   = mem_q;
    busy_d  = busy_q;
    if (rst) begin
      mem_d  = '0;
      busy_d = '0;
    end else begin
      if (we_ok) begin
        mem_d[waddr]  = wdata;
        busy_d[waddr] = 1'b0;
      end
      // Applied after the clear: a newly issued producer outranks the completing write
      if (bset_ok) begin
        busy_d[baddr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    busy_q <= busy_d;
  end

  always_comb begin
    busy_vec = busy_q;
    busy_a   = addr_ok(32'(raddr_a), DEPTH, 1'b0) ? busy_q[raddr_a] : 1'b0;
    busy_b   = addr_ok(32'(raddr_b), DEPTH, 1'b0) ? busy_q[raddr_b] : 1'b0;
  end

  regfile_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_a (
    .clk  (clk),
    .rst  (rst),
    .re   (re_a),
    .raddr(raddr_a),
    .mem  (mem_q),
    .we_ok(we_ok),
    .waddr(waddr),
    .wdata(wdata),
    .rdata(rdata_a)
  );

  regfile_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_b (
    .clk  (clk),
    .rst  (rst),
    .re   (re_b),
    .raddr(raddr_b),
    .mem  (mem_q),
    .we_ok(we_ok),
    .waddr(waddr),
    .wdata(wdata),
    .rdata(rdata_b)
  );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb/tb_regfile_2r1w_sb.sv - directed vector bench over default, no-bypass, no-zero-reg and DEPTH=6 variants
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst, we, re_a, re_b, bset;
  logic [2:0]  waddr, raddr_a, raddr_b, baddr;
  logic [15:0] wdata;

  logic [15:0] def_ra, def_rb, nb_ra, nb_rb, nz_ra, nz_rb, d6_ra, d6_rb;
  logic        def_ba, def_bb, nb_ba, nb_bb, nz_ba, nz_bb, d6_ba, d6_bb;
  logic [7:0]  def_bv, nb_bv, nz_bv;
  logic [5:0]  d6_bv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_2r1w_sb u_def (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(def_ra),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(def_rb),
    .bset(bset), .baddr(baddr), .busy_a(def_ba), .busy_b(def_bb), .busy_vec(def_bv)
  );

  regfile_2r1w_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(nb_ra),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(nb_rb),
    .bset(bset), .baddr(baddr), .busy_a(nb_ba), .busy_b(nb_bb), .busy_vec(nb_bv)
  );

  regfile_2r1w_sb #(.ZERO_REG(1'b0)) u_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(nz_ra),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(nz_rb),
    .bset(bset), .baddr(baddr), .busy_a(nz_ba), .busy_b(nz_bb), .busy_vec(nz_bv)
  );

  regfile_2r1w_sb #(.DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(d6_ra),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(d6_rb),
    .bset(bset), .baddr(baddr), .busy_a(d6_ba), .busy_b(d6_bb), .busy_vec(d6_bv)
  );

  typedef struct {
    bit          rst, we;
    logic [2:0]  wa;
    logic [15:0] wd;
    bit          ea;
    logic [2:0]  a;
    bit          eb;
    logic [2:0]  b;
    bit          bs;
    logic [2:0]  ba;
    logic [15:0] xa, xb;
    bit          xba, xbb;
    logic [7:0]  xbv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit w, logic [2:0] wa, logic [15:0] wd,
                              bit ea, logic [2:0] a, bit eb, logic [2:0] b,
                              bit bs, logic [2:0] ba,
                              logic [15:0] xa, logic [15:0] xb, bit xba, bit xbb,
                              logic [7:0] xbv);
    vec_t v;
    v.rst = r;  v.we = w;  v.wa = wa; v.wd = wd;
    v.ea = ea;  v.a = a;   v.eb = eb; v.b = b;
    v.bs = bs;  v.ba = ba;
    v.xa = xa;  v.xb = xb; v.xba = xba; v.xbb = xbb; v.xbv = xbv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(bit r, bit w, logic [2:0] wa, logic [15:0] wd,
                        bit ea, logic [2:0] a, bit eb, logic [2:0] b,
                        bit bs, logic [2:0] ba);
    rst = r;  we = w;  waddr = wa; wdata = wd;
    re_a = ea; raddr_a = a; re_b = eb; raddr_b = b;
    bset = bs; baddr = ba;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, fill 1..7, reset with competing write/bset, read everything back as zero
    vq.push_back(mk(1,0,0,16'h0, 0,0,0,0, 0,0, 16'h0,16'h0,0,0,8'h00));
    for (int i = 1; i < 8; i++)
      vq.push_back(mk(0,1,3'(i),16'(16'h1111 * i), 0,0,0,0, 0,0, 16'h0,16'h0,0,0,8'h00));
    vq.push_back(mk(0,0,0,16'h0, 1,7,1,1, 0,0, 16'h7777,16'h1111,0,0,8'h00));
    vq.push_back(mk(1,1,3,16'hFFFF, 1,7,0,0, 1,4, 16'h0,16'h0,0,0,8'h00));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0,0,0,16'h0, 1,3'(i),1,3'(7 - i), 0,0, 16'h0,16'h0,0,0,8'h00));
    // Write then read, then hold with re low
    vq.push_back(mk(0,1,3,16'hBEEF, 0,0,0,0, 0,0, 16'h0,16'h0,0,0,8'h00));
    vq.push_back(mk(0,0,0,16'h0, 1,3,0,0, 0,0, 16'hBEEF,16'h0,0,0,8'h00));
    vq.push_back(mk(0,0,0,16'h0, 0,5,0,0, 0,0, 16'hBEEF,16'h0,0,0,8'h00));
    // Bypass on both ports
    vq.push_back(mk(0,1,5,16'h0001, 0,0,0,0, 0,0, 16'hBEEF,16'h0,0,0,8'h00));
    vq.push_back(mk(0,1,5,16'hA5A5, 1,5,1,5, 0,0, 16'hA5A5,16'hA5A5,0,0,8'h00));
    vq.push_back(mk(0,0,0,16'h0, 1,5,0,0, 0,0, 16'hA5A5,16'hA5A5,0,0,8'h00));
    // Zero register
    vq.push_back(mk(0,1,0,16'hFFFF, 0,0,0,0, 1,0, 16'hA5A5,16'hA5A5,0,0,8'h00));
    vq.push_back(mk(0,0,0,16'h0, 1,0,1,0, 0,0, 16'h0,16'h0,0,0,8'h00));
    // Scoreboard set, clear, set-wins, independent set/clear
    vq.push_back(mk(0,0,0,16'h0, 0,2,0,0, 1,2, 16'h0,16'h0,1,0,8'h04));
    vq.push_back(mk(0,1,2,16'h1234, 0,2,0,0, 0,0, 16'h0,16'h0,0,0,8'h00));
    vq.push_back(mk(0,1,2,16'h5678, 0,2,0,0, 1,2, 16'h0,16'h0,1,0,8'h04));
    vq.push_back(mk(0,0,0,16'h0, 1,2,0,0, 0,0, 16'h5678,16'h0,1,0,8'h04));
    vq.push_back(mk(0,1,2,16'h9ABC, 1,4,1,2, 1,4, 16'h0,16'h9ABC,1,0,8'h10));

    #1;
    foreach (vq[i]) begin
      set_in(vq[i].rst, vq[i].we, vq[i].wa, vq[i].wd, vq[i].ea, vq[i].a,
             vq[i].eb, vq[i].b, vq[i].bs, vq[i].ba);
      tick();
      chk($sformatf("row%0d rdata_a", i), 32'(def_ra), 32'(vq[i].xa));
      chk($sformatf("row%0d rdata_b", i), 32'(def_rb), 32'(vq[i].xb));
      chk($sformatf("row%0d busy_a", i), 32'(def_ba), 32'(vq[i].xba));
      chk($sformatf("row%0d busy_b", i), 32'(def_bb), 32'(vq[i].xbb));
      chk($sformatf("row%0d busy_vec", i), 32'(def_bv), 32'(vq[i].xbv));
    end

    // BYPASS=0 returns the old value on a same-cycle write
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 5, 16'h0001, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 5, 16'hA5A5, 1, 5, 1, 5, 0, 0); tick();
    chk("nobyp rdata_a old", 32'(nb_ra), 32'h0001);
    chk("nobyp rdata_b old", 32'(nb_rb), 32'h0001);
    chk("byp rdata_a fwd", 32'(def_ra), 32'hA5A5);
    set_in(0, 0, 0, 0, 1, 5, 0, 0, 0, 0); tick();
    chk("nobyp rdata_a new", 32'(nb_ra), 32'hA5A5);

    // ZERO_REG=0 makes entry 0 an ordinary register
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 1, 0); tick();
    chk("nozero busy_vec", 32'(nz_bv), 32'h01);
    chk("zero busy_vec", 32'(def_bv), 32'h00);
    set_in(0, 0, 0, 0, 1, 0, 1, 0, 0, 0); tick();
    chk("nozero rdata_a", 32'(nz_ra), 32'hFFFF);
    chk("nozero busy_a", 32'(nz_ba), 32'h1);
    chk("zero rdata_a", 32'(def_ra), 32'h0000);
    chk("zero busy_a", 32'(def_ba), 32'h0);

    // DEPTH=6: out-of-range writes, reads and bsets have no effect
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 1; i < 6; i++) begin
      set_in(0, 1, 3'(i), 16'(16'h1000 + i), 0, 0, 0, 0, 0, 0); tick();
    end
    set_in(0, 1, 7, 16'h7777, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 6, 16'h6666, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 1; i < 6; i++) begin
      set_in(0, 0, 0, 0, 1, 3'(i), 1, 3'(6 + (i % 2)), 0, 0); tick();
      chk($sformatf("d6 entry%0d", i), 32'(d6_ra), 32'h1000 + i);
      chk($sformatf("d6 oor read%0d", i), 32'(d6_rb), 32'h0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 6); tick();
    chk("d6 bset6 busy_vec", 32'(d6_bv), 32'h00);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
    chk("d6 bset7 busy_vec", 32'(d6_bv), 32'h00);
    set_in(0, 0, 0, 0, 0, 5, 0, 6, 1, 5); tick();
    chk("d6 bset5 busy_vec", 32'(d6_bv), 32'h20);
    chk("d6 busy_a entry5", 32'(d6_ba), 32'h1);
    chk("d6 busy_b oor", 32'(d6_bb), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
